// File: rtl/ag32gbd_bram_arb_if.sv
// ag32gbd_bram_arb_if: requester, register-block and BRAM signals of the camera BRAM arbiter
interface ag32gbd_bram_arb_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              Rd_Req;
  logic [ADDR_W-1:0] Rd_Addr;
  logic              Rd_Valid;
  logic [DATA_W-1:0] Rd_Data;
  logic              Cap_Wr_Valid;
  logic [ADDR_W-1:0] Cap_Wr_Addr;
  logic [DATA_W-1:0] Cap_Wr_Data;
  logic              Cap_Wr_Ready;
  logic              Cap_Busy;
  logic              Reg_Req_Write;
  logic [ADDR_W-1:0] Reg_Addr;
  logic [DATA_W-1:0] Reg_Data;
  logic              Reg_WriteDone;
  logic              Bram_En;
  logic              Bram_We;
  logic [ADDR_W-1:0] Bram_Addr;
  logic [DATA_W-1:0] Bram_Wdata;
  logic [DATA_W-1:0] Bram_Rdata;
  modport slave (
    input  Rd_Req, Rd_Addr, Cap_Wr_Valid, Cap_Wr_Addr, Cap_Wr_Data, Cap_Busy,
           Reg_Req_Write, Reg_Addr, Reg_Data, Bram_Rdata,
    output Rd_Valid, Rd_Data, Cap_Wr_Ready, Reg_WriteDone,
           Bram_En, Bram_We, Bram_Addr, Bram_Wdata
  );
  modport master (
    output Rd_Req, Rd_Addr, Cap_Wr_Valid, Cap_Wr_Addr, Cap_Wr_Data, Cap_Busy,
           Reg_Req_Write, Reg_Addr, Reg_Data, Bram_Rdata,
    input  Rd_Valid, Rd_Data, Cap_Wr_Ready, Reg_WriteDone,
           Bram_En, Bram_We, Bram_Addr, Bram_Wdata
  );
endinterface

// File: rtl/ag32gbd_bram_arb.sv
// ag32gbd_bram_arb: single-port camera BRAM arbiter for read-back, capture writer and register writer
module ag32gbd_bram_arb #(
  parameter int                ADDR_W       = 10,
  parameter int                DATA_W       = 8,
  parameter logic [ADDR_W-1:0] DITHER_BASE  = 10'h200,
  parameter int                STARVE_LIMIT = 8
) (
  input logic               sys_clock,
  input logic               sys_reset,
  ag32gbd_bram_arb_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_ISSUED = 2'd2, S_DONE = 2'd3;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [1:0]        state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d, bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0] reg_data_q, reg_data_d, bram_wdata_q, bram_wdata_d, rd_data_q, rd_data_d;
  logic              bram_en_q, bram_en_d, bram_we_q, bram_we_d;
  logic              rd1_q, rd1_d, rd2_q, rd2_d, rd_valid_q, rd_valid_d;
  logic              eligible, urgent, cap_ready, cap_gnt, reg_gnt, latch;
  // A dither-region write waits out the whole capture so the matrix stays stable per frame
  always_comb begin
    eligible     = state_q == S_REQ && !(reg_addr_q >= DITHER_BASE && bus.Cap_Busy);
    urgent       = eligible && starve_q >= LIMIT;
    cap_ready    = !sys_reset && !bus.Rd_Req && !urgent;
    cap_gnt      = cap_ready && bus.Cap_Wr_Valid;
    reg_gnt      = !bus.Rd_Req && (urgent || (eligible && !bus.Cap_Wr_Valid));
    latch        = state_q == S_IDLE && bus.Reg_Req_Write;
    state_d      = state_q == S_IDLE   ? (bus.Reg_Req_Write ? S_REQ : S_IDLE)
                 : state_q == S_REQ    ? (reg_gnt ? S_ISSUED : S_REQ)
                 : state_q == S_ISSUED ? S_DONE : S_IDLE;
    reg_addr_d   = latch ? bus.Reg_Addr : reg_addr_q;
    reg_data_d   = latch ? bus.Reg_Data : reg_data_q;
    starve_d     = (eligible && !reg_gnt) ? (starve_q == 4'hF ? starve_q : starve_q + 4'd1) : 4'd0;
    bram_en_d    = bus.Rd_Req || cap_gnt || reg_gnt;
    bram_we_d    = cap_gnt || reg_gnt;
    bram_addr_d  = bus.Rd_Req ? bus.Rd_Addr : reg_gnt ? reg_addr_q : cap_gnt ? bus.Cap_Wr_Addr : bram_addr_q;
    bram_wdata_d = reg_gnt ? reg_data_q : cap_gnt ? bus.Cap_Wr_Data : bram_wdata_q;
    rd1_d        = bus.Rd_Req;
    rd2_d        = rd1_q;
    rd_valid_d   = rd2_q;
    rd_data_d    = rd2_q ? bus.Bram_Rdata : rd_data_q;
  end
  always_ff @(posedge sys_clock) begin
    if (sys_reset) begin
      state_q      <= S_IDLE;
      starve_q     <= '0;
      reg_addr_q   <= '0;
      reg_data_q   <= '0;
      bram_en_q    <= 1'b0;
      bram_we_q    <= 1'b0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
      rd1_q        <= 1'b0;
      rd2_q        <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      reg_addr_q   <= reg_addr_d;
      reg_data_q   <= reg_data_d;
      bram_en_q    <= bram_en_d;
      bram_we_q    <= bram_we_d;
      bram_addr_q  <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
    end
  end
  assign bus.Rd_Valid      = rd_valid_q;
  assign bus.Rd_Data       = rd_data_q;
  assign bus.Cap_Wr_Ready  = cap_ready;
  assign bus.Reg_WriteDone = state_q == S_DONE;
  assign bus.Bram_En       = bram_en_q;
  assign bus.Bram_We       = bram_we_q;
  assign bus.Bram_Addr     = bram_addr_q;
  assign bus.Bram_Wdata    = bram_wdata_q;
endmodule
